bf_sdf_stage: RTL



---
 rtl/bf_pkg.sv | 13 +
 rtl/bf_add_sub.sv | 37 +++
 rtl/bf_sdf_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the radix-2 single-path delay-feedback butterfly stage.
// The lane vector types depend on WIDTH, so each module derives them from LANES.
package bf_pkg;

  localparam int LANES = 16;

  typedef enum logic [1:0] {
    FILL,
    COMBINE,
    DRAIN
  } bf_state_e;

endpackage

// File: rtl/bf_add_sub.sv
// Per-block complex adder/subtractor: sum = a + b, diff = a - b per lane and component.
// When BF_SCALE_EN is defined the sum output is halved (arithmetic shift, floor); diff stays unscaled.
module bf_add_sub #(
  parameter int WIDTH = 9,
  parameter int LANES = bf_pkg::LANES
) (
  input  logic [LANES-1:0][WIDTH:0]   i_a_real,
  input  logic [LANES-1:0][WIDTH:0]   i_a_imag,
  input  logic [LANES-1:0][WIDTH-1:0] i_b_real,
  input  logic [LANES-1:0][WIDTH-1:0] i_b_imag,
  output logic [LANES-1:0][WIDTH:0]   o_sum_real,
  output logic [LANES-1:0][WIDTH:0]   o_sum_imag,
  output logic [LANES-1:0][WIDTH:0]   o_diff_real,
  output logic [LANES-1:0][WIDTH:0]   o_diff_imag
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH:0] w_sum_real;
    logic [WIDTH:0] w_sum_imag;

    // a never exceeds the WIDTH-bit range when b is non-zero, so WIDTH+1 bits cannot wrap.
    assign w_sum_real = i_a_real[l] + {i_b_real[l][WIDTH-1], i_b_real[l]};
    assign w_sum_imag = i_a_imag[l] + {i_b_imag[l][WIDTH-1], i_b_imag[l]};

    assign o_diff_real[l] = i_a_real[l] - {i_b_real[l][WIDTH-1], i_b_real[l]};
    assign o_diff_imag[l] = i_a_imag[l] - {i_b_imag[l][WIDTH-1], i_b_imag[l]};

`ifdef BF_SCALE_EN
    assign o_sum_real[l] = {w_sum_real[WIDTH], w_sum_real[WIDTH:1]};
    assign o_sum_imag[l] = {w_sum_imag[WIDTH], w_sum_imag[WIDTH:1]};
`else
    assign o_sum_real[l] = w_sum_real;
    assign o_sum_imag[l] = w_sum_imag;
`endif
  end

endmodule

// File: rtl/bf_sdf_stage.sv
// Radix-2 SDF butterfly stage: FILL stores D blocks, COMBINE emits sums and stores diffs, DRAIN emits diffs.
// Optional BF_SCALE_EN (see bf_add_sub) halves every output sample.
module bf_sdf_stage import bf_pkg::*; #(
  parameter int WIDTH        = 9,
  parameter int DELAY_LENGTH = 16,
  parameter int LANES        = bf_pkg::LANES
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES-1:0][WIDTH-1:0] din_real,
  input  logic [LANES-1:0][WIDTH-1:0] din_imag,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [LANES-1:0][WIDTH:0]   dout_real,
  output logic [LANES-1:0][WIDTH:0]   dout_imag,
  output logic                        dly_write,
  output logic                        dly_read,
  output logic [LANES-1:0][WIDTH:0]   dly_wdata_real,
  output logic [LANES-1:0][WIDTH:0]   dly_wdata_imag,
  input  logic [LANES-1:0][WIDTH:0]   dly_rdata_real,
  input  logic [LANES-1:0][WIDTH:0]   dly_rdata_imag
);

  localparam int CW = (DELAY_LENGTH > 1) ? $clog2(DELAY_LENGTH) : 1;

  bf_state_e                   r_state;
  logic [CW-1:0]               r_count;
  logic                        r_pend;
  logic                        r_drain_rd;
  logic                        r_drain_last;
  logic [LANES-1:0][WIDTH-1:0] r_b_real;
  logic [LANES-1:0][WIDTH-1:0] r_b_imag;
  logic                        r_out_valid;
  logic                        r_out_last;
  logic [LANES-1:0][WIDTH:0]   r_dout_real;
  logic [LANES-1:0][WIDTH:0]   r_dout_imag;

  logic                        w_accept;
  logic                        w_last_cnt;
  logic                        w_fill_wr;
  logic                        w_comb_rd;
  logic [LANES-1:0][WIDTH:0]   w_sext_real;
  logic [LANES-1:0][WIDTH:0]   w_sext_imag;
  logic [LANES-1:0][WIDTH-1:0] w_b_real;
  logic [LANES-1:0][WIDTH-1:0] w_b_imag;
  logic [LANES-1:0][WIDTH:0]   w_sum_real;
  logic [LANES-1:0][WIDTH:0]   w_sum_imag;
  logic [LANES-1:0][WIDTH:0]   w_diff_real;
  logic [LANES-1:0][WIDTH:0]   w_diff_imag;

  assign in_ready   = (r_state != DRAIN);
  assign w_accept   = in_valid & in_ready;
  assign w_last_cnt = (r_count == CW'(DELAY_LENGTH - 1));
  assign w_fill_wr  = (r_state == FILL) & w_accept;
  assign w_comb_rd  = (r_state == COMBINE) & w_accept;

  assign dly_read  = w_comb_rd | (r_state == DRAIN);
  assign dly_write = w_fill_wr | r_pend;

  for (genvar l = 0; l < LANES; l++) begin : g_sext
    assign w_sext_real[l] = {din_real[l][WIDTH-1], din_real[l]};
    assign w_sext_imag[l] = {din_imag[l][WIDTH-1], din_imag[l]};
  end

  // DRAIN reuses the adder with b = 0 so the stored diff picks up the same output scaling.
  assign w_b_real = r_pend ? r_b_real : '0;
  assign w_b_imag = r_pend ? r_b_imag : '0;

  bf_add_sub #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_add_sub (
    .i_a_real    (dly_rdata_real),
    .i_a_imag    (dly_rdata_imag),
    .i_b_real    (w_b_real),
    .i_b_imag    (w_b_imag),
    .o_sum_real  (w_sum_real),
    .o_sum_imag  (w_sum_imag),
    .o_diff_real (w_diff_real),
    .o_diff_imag (w_diff_imag)
  );

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    dly_wdata_real = '0;
    dly_wdata_imag = '0;
    if (w_fill_wr) begin
      dly_wdata_real = w_sext_real;
      dly_wdata_imag = w_sext_imag;
    end else if (r_pend) begin
      dly_wdata_real = w_diff_real;
      dly_wdata_imag = w_diff_imag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= FILL;
      r_count      <= '0;
      r_pend       <= 1'b0;
      r_drain_rd   <= 1'b0;
      r_drain_last <= 1'b0;
      r_b_real     <= '0;
      r_b_imag     <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_dout_real  <= '0;
      r_dout_imag  <= '0;
    end else begin
      r_pend       <= w_comb_rd;
      r_drain_rd   <= (r_state == DRAIN);
      r_drain_last <= (r_state == DRAIN) & w_last_cnt;
      r_out_valid  <= r_pend | r_drain_rd;
      r_out_last   <= r_drain_last;

      if (w_comb_rd) begin
        r_b_real <= din_real;
        r_b_imag <= din_imag;
      end

      if (r_pend | r_drain_rd) begin
        r_dout_real <= w_sum_real;
        r_dout_imag <= w_sum_imag;
      end

      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_count <= w_last_cnt ? '0 : r_count + CW'(1);
            if (w_last_cnt) r_state <= COMBINE;
          end
        end
        COMBINE: begin
          if (w_accept) begin
            r_count <= w_last_cnt ? '0 : r_count + CW'(1);
            if (w_last_cnt) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_count <= w_last_cnt ? '0 : r_count + CW'(1);
          if (w_last_cnt) r_state <= FILL;
        end
        default: begin
          r_state <= FILL;
          r_count <= '0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign dout_real = r_dout_real;
  assign dout_imag = r_dout_imag;

endmodule
